saa_bus_seq: RTL and testbench

- Write sequencer between the Z80 port decoder and the SAA1099 bus pins.
- Accepts single-cycle write requests (A0 + data) in the fclk domain.
- Replays each request as a CS_n/WR_n/A0/D bus cycle, with setup, strobe, hold and gap widths counted in fclk cycles.
- Has a one-entry pending buffer so back-to-back Z80 OUTs are not lost. Gated by the same saa_enabled that gates the SAA clock.

---
 rtl/turbofm_pkg.sv | 33 +++
 rtl/saa_req_slot.sv | 51 +++++
 rtl/saa_bus_seq.sv | 146 ++++++++++++++
 tb/tb_saa_bus_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/turbofm_pkg.sv
// Shared types and timing constants for the TurboFM sound blocks.
// Every cycle count here is measured in 56 MHz fclk cycles.
package turbofm_pkg;

    localparam int FCLK_HZ = 56_000_000;

    // Counter width for the per-state cycle counters.
    localparam int CNT_W = 4;

    localparam int SAA_SETUP_CYC = 2;
    localparam int SAA_PULSE_CYC = 8;
    localparam int SAA_HOLD_CYC  = 2;
    localparam int SAA_GAP_CYC   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_GAP
    } saa_state_e;

    typedef struct packed {
        logic       a0;
        logic [7:0] data;
    } saa_req_t;

    // A state lasts n cycles, so the down-counter is loaded with n-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/saa_req_slot.sv
// One-entry pending buffer in front of the SAA write sequencer.
// It can refill in the same cycle it drains, and it reports dropped requests on ovf.
module saa_req_slot
    import turbofm_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     req,
    input  saa_req_t req_in,
    input  logic     idle,
    input  logic     drain,
    output logic     vld,
    output logic     out_vld,
    output saa_req_t out,
    output logic     ovf
);

    saa_req_t pend;
    logic     accept;
    logic     drop;
    logic     bypass;

    // A request in IDLE goes straight to the sequencer, so it never reaches this slot.
    assign accept = en && req && !idle && (!vld || drain);
    assign drop   = en && req && !idle && vld && !drain;
    // When the slot is empty and being drained, the new request passes straight through.
    assign bypass = accept && !vld && drain;

    assign out_vld = vld || (accept && !vld);
    assign out     = vld ? pend : req_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            pend <= '0;
            ovf  <= 1'b0;
        end else begin
            ovf <= drop;
            if (!en) begin
                vld <= 1'b0;
            end else if (accept && !bypass) begin
                vld  <= 1'b1;
                pend <= req_in;
            end else if (drain) begin
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/saa_bus_seq.sv
// Replays Z80 port writes as SAA1099 CS_n/WR_n bus cycles.
// Every pin is registered from the next-state value, so no combinational path runs from req to a pin.
module saa_bus_seq
    import turbofm_pkg::*;
#(
    parameter int SETUP_CYC = SAA_SETUP_CYC,
    parameter int PULSE_CYC = SAA_PULSE_CYC,
    parameter int HOLD_CYC  = SAA_HOLD_CYC,
    parameter int GAP_CYC   = SAA_GAP_CYC
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       saa_enabled,
    input  logic       req,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       ovf,
    output logic       saa_cs_n,
    output logic       saa_wr_n,
    output logic       saa_a0,
    output logic [7:0] saa_d,
    output logic       saa_d_oe
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (SETUP_CYC < 1 || SETUP_CYC > CNT_MAX || PULSE_CYC < 1 || PULSE_CYC > CNT_MAX ||
        HOLD_CYC < 1 || HOLD_CYC > CNT_MAX || GAP_CYC < 1 || GAP_CYC > CNT_MAX) begin : g_bad_param
        $error("saa_bus_seq: timing parameters must be in 1..15");
    end

    saa_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    saa_req_t         cur, cur_n, pend;
    logic             pend_vld, pend_out_vld;
    logic             idle, drain;
    logic             cs_n_n, wr_n_n, d_oe_n;

    assign idle  = (state == ST_IDLE);
    assign drain = saa_enabled && (state == ST_GAP) && (cnt == '0);
    assign busy  = !idle || pend_vld;

    saa_req_slot u_slot (
        .clk     (fclk),
        .rst     (rst),
        .en      (saa_enabled),
        .req     (req),
        .req_in  ('{a0: req_a0, data: req_data}),
        .idle    (idle),
        .drain   (drain),
        .vld     (pend_vld),
        .out_vld (pend_out_vld),
        .out     (pend),
        .ovf     (ovf)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur;
        case (state)
            ST_IDLE: if (saa_enabled && req) begin
                state_n = ST_SETUP;
                cnt_n   = cnt_load(SETUP_CYC);
                cur_n   = '{a0: req_a0, data: req_data};
            end
            // Losing enable before the strobe aborts cleanly; once WR_n is low it completes.
            ST_SETUP: if (!saa_enabled) begin
                state_n = ST_GAP;
                cnt_n   = cnt_load(GAP_CYC);
            end else if (cnt == '0) begin
                state_n = ST_STROBE;
                cnt_n   = cnt_load(PULSE_CYC);
            end else begin
                cnt_n = cnt - 1'b1;
            end
            ST_STROBE: if (cnt == '0) begin
                state_n = ST_HOLD;
                cnt_n   = cnt_load(HOLD_CYC);
            end else begin
                cnt_n = cnt - 1'b1;
            end
            ST_HOLD: if (cnt == '0) begin
                state_n = ST_GAP;
                cnt_n   = cnt_load(GAP_CYC);
            end else begin
                cnt_n = cnt - 1'b1;
            end
            ST_GAP: if (cnt == '0) begin
                if (drain && pend_out_vld) begin
                    state_n = ST_SETUP;
                    cnt_n   = cnt_load(SETUP_CYC);
                    cur_n   = pend;
                end else begin
                    state_n = ST_IDLE;
                end
            end else begin
                cnt_n = cnt - 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase

        // A disabled, idle SAA sees the same pins as after reset.
        if (state_n == ST_IDLE && !saa_enabled)
            cur_n = '0;

        cs_n_n = 1'b1;
        wr_n_n = 1'b1;
        d_oe_n = 1'b0;
        case (state_n)
            ST_SETUP, ST_HOLD: begin
                cs_n_n = 1'b0;
                d_oe_n = 1'b1;
            end
            ST_STROBE: begin
                cs_n_n = 1'b0;
                wr_n_n = 1'b0;
                d_oe_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur      <= '0;
            saa_cs_n <= 1'b1;
            saa_wr_n <= 1'b1;
            saa_d_oe <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur      <= cur_n;
            saa_cs_n <= cs_n_n;
            saa_wr_n <= wr_n_n;
            saa_d_oe <= d_oe_n;
        end
    end

    assign saa_a0 = cur.a0;
    assign saa_d  = cur.data;

endmodule

// File: tb/tb_saa_bus_seq.sv
// Directed vector bench for saa_bus_seq: a per-cycle table of inputs and expected pins,
// followed by a hand-written reset-mid-strobe sequence.
module tb_saa_bus_seq;

    logic       fclk = 1'b0;
    logic       rst;
    logic       saa_enabled;
    logic       req;
    logic       req_a0;
    logic [7:0] req_data;
    logic       busy, ovf, saa_cs_n, saa_wr_n, saa_a0, saa_d_oe;
    logic [7:0] saa_d;

    int errors = 0;
    int checks = 0;

    saa_bus_seq dut (
        .fclk        (fclk),
        .rst         (rst),
        .saa_enabled (saa_enabled),
        .req         (req),
        .req_a0      (req_a0),
        .req_data    (req_data),
        .busy        (busy),
        .ovf         (ovf),
        .saa_cs_n    (saa_cs_n),
        .saa_wr_n    (saa_wr_n),
        .saa_a0      (saa_a0),
        .saa_d       (saa_d),
        .saa_d_oe    (saa_d_oe)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic       rq;
        logic       a0;
        logic [7:0] d;
        logic       en;
        logic       cs_n;
        logic       wr_n;
        logic       oe;
        logic       busy;
        logic       ovf;
        logic       ea0;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int n, input logic rq, input logic a0, input logic [7:0] d,
                                input logic en, input logic cs_n, input logic wr_n, input logic oe,
                                input logic b, input logic ov, input logic ea0, input logic [7:0] ed);
        vec_t v;
        v = '{rq, a0, d, en, cs_n, wr_n, oe, b, ov, ea0, ed};
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic chk_pins(input string tag, input int idx, input logic cs_n, input logic wr_n,
                            input logic oe, input logic b, input logic ov, input logic ea0,
                            input logic [7:0] ed);
        chk({tag, ".cs_n"}, idx, {7'd0, saa_cs_n}, {7'd0, cs_n});
        chk({tag, ".wr_n"}, idx, {7'd0, saa_wr_n}, {7'd0, wr_n});
        chk({tag, ".d_oe"}, idx, {7'd0, saa_d_oe}, {7'd0, oe});
        chk({tag, ".busy"}, idx, {7'd0, busy}, {7'd0, b});
        chk({tag, ".ovf"}, idx, {7'd0, ovf}, {7'd0, ov});
        chk({tag, ".a0"}, idx, {7'd0, saa_a0}, {7'd0, ea0});
        chk({tag, ".d"}, idx, saa_d, ed);
    endtask

    initial begin
        rst = 1'b1; saa_enabled = 1'b1; req = 1'b0; req_a0 = 1'b0; req_data = 8'h00;
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset: 20 cycles of reset-valued pins.
        add(20, 0,0,8'h00,1,  1,1,0,0,0, 0,8'h00);

        // Single write a0=1 data=1C; the req cycle is cycle 0.
        add(1,  1,1,8'h1C,1,  1,1,0,0,0, 0,8'h00);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 1,8'h1C);
        add(8,  0,0,8'h00,1,  0,0,1,1,0, 1,8'h1C);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 1,8'h1C);
        add(2,  0,0,8'h00,1,  1,1,0,1,0, 1,8'h1C);
        add(1,  0,0,8'h00,1,  1,1,0,0,0, 1,8'h1C);

        // Three back-to-back reqs: 00 runs, 05 waits in pending, FF is dropped.
        add(1,  1,1,8'h00,1,  1,1,0,0,0, 1,8'h1C);
        add(1,  1,0,8'h05,1,  0,1,1,1,0, 1,8'h00);
        add(1,  1,1,8'hFF,1,  0,1,1,1,0, 1,8'h00);
        add(1,  0,0,8'h00,1,  0,0,1,1,1, 1,8'h00);
        add(7,  0,0,8'h00,1,  0,0,1,1,0, 1,8'h00);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 1,8'h00);
        add(2,  0,0,8'h00,1,  1,1,0,1,0, 1,8'h00);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 0,8'h05);
        add(8,  0,0,8'h00,1,  0,0,1,1,0, 0,8'h05);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 0,8'h05);
        add(2,  0,0,8'h00,1,  1,1,0,1,0, 0,8'h05);
        add(1,  0,0,8'h00,1,  1,1,0,0,0, 0,8'h05);

        // Req in the last GAP cycle with pending empty: SETUP follows directly.
        add(1,  1,0,8'hAA,1,  1,1,0,0,0, 0,8'h05);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 0,8'hAA);
        add(8,  0,0,8'h00,1,  0,0,1,1,0, 0,8'hAA);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 0,8'hAA);
        add(1,  0,0,8'h00,1,  1,1,0,1,0, 0,8'hAA);
        add(1,  1,1,8'h55,1,  1,1,0,1,0, 0,8'hAA);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 1,8'h55);
        add(8,  0,0,8'h00,1,  0,0,1,1,0, 1,8'h55);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 1,8'h55);
        add(2,  0,0,8'h00,1,  1,1,0,1,0, 1,8'h55);
        add(1,  0,0,8'h00,1,  1,1,0,0,0, 1,8'h55);

        // Disable during SETUP with pending full: abort to GAP, flush, no strobe.
        add(1,  1,1,8'h33,1,  1,1,0,0,0, 1,8'h55);
        add(1,  1,0,8'h44,1,  0,1,1,1,0, 1,8'h33);
        add(1,  0,0,8'h00,0,  0,1,1,1,0, 1,8'h33);
        add(1,  1,1,8'h77,0,  1,1,0,1,0, 1,8'h33);
        add(1,  0,0,8'h00,0,  1,1,0,1,0, 1,8'h33);
        add(1,  1,1,8'h77,0,  1,1,0,0,0, 0,8'h00);
        add(4,  0,0,8'h00,0,  1,1,0,0,0, 0,8'h00);
        add(5,  0,0,8'h00,1,  1,1,0,0,0, 0,8'h00);

        // Disable mid-STROBE: the 8-cycle strobe still completes.
        add(1,  1,0,8'h99,1,  1,1,0,0,0, 0,8'h00);
        add(2,  0,0,8'h00,1,  0,1,1,1,0, 0,8'h99);
        add(2,  0,0,8'h00,1,  0,0,1,1,0, 0,8'h99);
        add(6,  0,0,8'h00,0,  0,0,1,1,0, 0,8'h99);
        add(2,  0,0,8'h00,0,  0,1,1,1,0, 0,8'h99);
        add(2,  0,0,8'h00,0,  1,1,0,1,0, 0,8'h99);
        add(2,  0,0,8'h00,0,  1,1,0,0,0, 0,8'h00);
        add(1,  0,0,8'h00,1,  1,1,0,0,0, 0,8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            req = vecs[i].rq; req_a0 = vecs[i].a0; req_data = vecs[i].d; saa_enabled = vecs[i].en;
            chk_pins("vec", i, vecs[i].cs_n, vecs[i].wr_n, vecs[i].oe, vecs[i].busy, vecs[i].ovf,
                     vecs[i].ea0, vecs[i].ed);
            step();
        end

        // Reset asserted mid-STROBE ends the transaction at the next edge.
        saa_enabled = 1'b1; req = 1'b1; req_a0 = 1'b1; req_data = 8'hE1;
        step();
        req = 1'b0; req_a0 = 1'b0; req_data = 8'h00;
        repeat (4) step();
        chk("rst_pre.wr_n", 0, {7'd0, saa_wr_n}, 8'd0);
        chk("rst_pre.d", 0, saa_d, 8'hE1);
        rst = 1'b1;
        step();
        chk_pins("rst_mid", 1, 1,1,0,0,0, 0,8'h00);
        rst = 1'b0;
        step();
        chk_pins("rst_post", 2, 1,1,0,0,0, 0,8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
